// File: rtl/aer_encoder.sv
// Address-event encoder: timestamps one-cycle neuron spikes, arbitrates
// them round-robin and queues {addr, time} events in a fall-through FIFO.
module aer_encoder #(
   parameter int N_NEUR = 4,
   parameter int DEPTH  = 8,
   parameter int TS_W   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_NEUR-1:0]          spike_in,
   input  logic                       aer_ready,
   output logic                       aer_valid,
   output logic [$clog2(N_NEUR)-1:0]  aer_addr,
   output logic [TS_W-1:0]            aer_time,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic [7:0]                 drop_count
);

   localparam int AW = $clog2(N_NEUR);
   localparam int DW = $clog2(DEPTH);
   localparam int CW = DW + 1;

   logic [TS_W-1:0]   ts;
   logic [N_NEUR-1:0] pending;
   logic [TS_W-1:0]   pend_ts [N_NEUR];
   logic [AW-1:0]     rr_ptr;
   logic [AW-1:0]     grant;
   logic              found;
   int                idx;

   logic [AW-1:0]     mem_addr [DEPTH];
   logic [TS_W-1:0]   mem_time [DEPTH];
   logic [DW-1:0]     wptr;
   logic [DW-1:0]     rptr;

   logic              push;
   logic              pop;
   logic [N_NEUR-1:0] gmask;
   logic [N_NEUR-1:0] drop_vec;
   logic [3:0]        drops;
   logic [8:0]        drop_sum;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N_NEUR; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_NEUR)
            idx = idx - N_NEUR;
         if (!found && pending[idx]) begin
            found = 1'b1;
            grant = AW'(idx);
         end
      end
   end

   assign aer_valid = (fifo_count != '0);
   assign aer_addr  = mem_addr[rptr];
   assign aer_time  = mem_time[rptr];
   assign pop       = aer_valid && aer_ready;
   assign push      = (|pending) && ((fifo_count < CW'(DEPTH)) || pop);
   assign gmask     = push ? (N_NEUR'(1) << grant) : '0;

   // A re-spike on the neuron being pushed this cycle is recaptured, not lost.
   assign drop_vec  = spike_in & pending & ~gmask;

   always_comb begin
      drops = '0;
      for (int i = 0; i < N_NEUR; i++)
         drops = drops + {3'b000, drop_vec[i]};
      drop_sum = {1'b0, drop_count} + {5'b00000, drops};
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wptr] <= grant;
         mem_time[wptr] <= pend_ts[grant];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ts         <= '0;
         pending    <= '0;
         rr_ptr     <= '0;
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
         drop_count <= '0;
         for (int i = 0; i < N_NEUR; i++)
            pend_ts[i] <= '0;
      end else begin
         ts <= ts + TS_W'(1);
         if (push) begin
            wptr   <= wptr + DW'(1);
            rr_ptr <= (grant == AW'(N_NEUR - 1)) ? '0 : grant + AW'(1);
         end
         if (pop)
            rptr <= rptr + DW'(1);
         if (push && !pop)
            fifo_count <= fifo_count + CW'(1);
         else if (pop && !push)
            fifo_count <= fifo_count - CW'(1);
         for (int i = 0; i < N_NEUR; i++) begin
            if (spike_in[i] && (!pending[i] || gmask[i])) begin
               pending[i] <= 1'b1;
               pend_ts[i] <= ts;
            end else if (gmask[i]) begin
               pending[i] <= 1'b0;
            end
         end
         drop_count <= (drop_sum > 9'd255) ? 8'hff : drop_sum[7:0];
      end
   end

endmodule

// File: doc/aer_encoder.md
AER_ENCODER -- requirements
Module: aer_encoder

Interface
REQ-001 Parameter N_NEUR, 4, number of spike inputs; legal values 2..8.
REQ-002 Parameter DEPTH, 8, FIFO entries; power of two, 2..32.
REQ-003 Parameter TS_W, 8, timestamp width.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 spike_in  in  N_NEUR  one-cycle spike pulses, one bit per LIF neuron.
REQ-008 aer_ready  in  1  downstream accepts the head event this cycle.
REQ-009 aer_valid  out  1  head event present.
REQ-010 aer_addr  out  clog2(N_NEUR)  neuron index of the head event.
REQ-011 aer_time  out  TS_W  timestamp of the head event.
REQ-012 fifo_count  out  clog2(DEPTH)+1  number of occupied FIFO entries.
REQ-013 drop_count  out  8  number of lost spikes, saturating.

Function
REQ-014 Timestamp counter ts increments by 1 on every non-reset edge and wraps from 2^TS_W-1 to 0.
REQ-015 Sampling: at each edge, every spike_in[i]=1 is captured into pending[i], with pend_ts[i] = ts value before that edge's increment.
REQ-016 Spike on neuron i while pending[i]=1 and i is not granted this cycle: spike is dropped, pend_ts[i] is unchanged, and drop_count increments unless it is already 255.
REQ-017 Spike on neuron i in the same cycle i is granted: pending[i] stays 1, pend_ts[i] takes the new timestamp, and no drop is counted.
REQ-018 Multiple simultaneous drops in one cycle add their total to drop_count, saturating at 255.
REQ-019 Arbiter: combinational round-robin over pending; grant goes to the first set bit at index >= rr_ptr, wrapping modulo N_NEUR.
REQ-020 Arbiter updates: rr_ptr = (grant+1) mod N_NEUR after each push; rr_ptr is unchanged when no push occurs.
REQ-021 Push of {grant, pend_ts[grant]} occurs when pending != 0 and (fifo_count < DEPTH or a pop occurs the same cycle); the granted pending bit clears, subject to REQ-017.
REQ-022 FIFO full and no pop: no push, pending is held, and no drop is counted.
REQ-023 Pop occurs when aer_valid && aer_ready; aer_ready while empty has no effect.
REQ-024 FIFO is first-word-fall-through: aer_valid = (fifo_count != 0), and aer_addr/aer_time show the head entry combinationally.
REQ-025 aer_addr and aer_time are held stable while aer_valid && !aer_ready.
REQ-026 Simultaneous push and pop leaves fifo_count unchanged, including when the FIFO is full.
REQ-027 Latency, empty FIFO and no contention: spike sampled at edge E0 gives aer_valid=1 in the cycle after edge E1.
REQ-028 Throughput is one push and one pop per cycle maximum.
REQ-029 FIFO read and write pointers wrap modulo DEPTH.

Reset
REQ-030 While reset=1 at an edge, the following clear to 0: ts, pending, pend_ts, rr_ptr, FIFO pointers, fifo_count, drop_count.
REQ-031 During reset, aer_valid=0 and spike_in is ignored.
REQ-032 Reset asserted mid-operation discards all buffered and pending events in one edge.
REQ-033 First event after reset carries aer_time equal to the number of edges since reset deasserted, minus 1.

Verification
REQ-034 Single spike: reset released, spike_in=0001 at the edge where ts=5, aer_ready=1 -> one cycle later aer_valid=1, aer_addr=0, aer_time=5, then empty.
REQ-035 Round-robin: spike_in=1111 for one edge at ts=10, aer_ready=1 -> events on consecutive cycles with addr 0,1,2,3, all time=10, rr_ptr=0 afterwards.
REQ-036 Backpressure and full: aer_ready=0, one spike per cycle rotating over the 4 neurons for 10 cycles -> fifo_count reaches 8 and stays there, pending holds the rest, drop_count rises only on re-spikes of pending neurons, and the head is stable.
REQ-037 Drop saturation: aer_ready=0, spike_in=0001 every cycle for 300 cycles -> drop_count=255 and holds.
REQ-038 Wrap: spike at ts=255, then spike at ts=0 on a different neuron -> aer_time 255 then 0, in order.
REQ-039 Reset mid-stream: FIFO holding 5 entries, reset asserted for 1 cycle -> aer_valid=0, fifo_count=0, drop_count=0, ts restarts at 0.
